// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core's load/store port and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked RV32I data-memory slave: one request at a time, programmable wait
// states, byte/half/word loads and stores with sign/zero extension and error flag.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned BYTE_AW   = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem [MEM_WORDS];

  logic               cur_write;
  logic [2:0]         cur_funct3;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic               cur_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]         lane;
  logic [31:0]        rd_word;
  logic [31:0]        rd_shift;
  logic [31:0]        load_data;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_shift;
  logic               accept;
  logic               enter_resp;
  logic               mem_we;

  // In IDLE the transaction is still on the bus (needed for zero-latency commit); afterwards use the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write  = bus.req_write;
      cur_funct3 = bus.req_funct3;
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
    end else begin
      cur_write  = write_q;
      cur_funct3 = funct3_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  assign word_idx = cur_addr[BYTE_AW-1:2];
  assign lane     = cur_addr[1:0];
  assign rd_word  = mem[word_idx];

  // Error decode: undefined funct3, misalignment, address beyond the array.
  always_comb begin
    cur_err = 1'b0;
    case (cur_funct3)
      3'b000: cur_err = 1'b0;
      3'b001: cur_err = cur_addr[0];
      3'b010: cur_err = (cur_addr[1:0] != 2'b00);
      3'b100: cur_err = cur_write;
      3'b101: cur_err = cur_write | cur_addr[0];
      default: cur_err = 1'b1;
    endcase
    if (|cur_addr[31:BYTE_AW]) begin
      cur_err = 1'b1;
    end
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    rd_shift  = rd_word >> {lane, 3'b000};
    load_data = 32'd0;
    case (cur_funct3)
      3'b000: load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001: load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010: load_data = rd_word;
      3'b100: load_data = {24'd0, rd_shift[7:0]};
      3'b101: load_data = {16'd0, rd_shift[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  // Store byte enables and lane-aligned write data.
  always_comb begin
    wdata_shift = cur_wdata << {lane, 3'b000};
    byte_en     = 4'b0000;
    case (cur_funct3)
      3'b000: byte_en = 4'b0001 << lane;
      3'b001: byte_en = 4'b0011 << lane;
      3'b010: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign accept     = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));
  assign mem_we     = enter_resp && cur_write && !cur_err && !reset;

  // Next-state, transaction latch and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      rsp_rdata_d = (!cur_write && !cur_err) ? load_data : 32'd0;
      rsp_error_d = cur_err;
    end

    rsp_valid_d = (state_d == S_RESP);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // Control and response registers; reset drops any pending transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Byte-masked store commit; array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_shift[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios, randomized traffic
// against a byte-array reference model, and a zero-latency instance.
module tb_data_mem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if mif ();
  data_mem_responder_if mif0 ();

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (mif0)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];
  logic [7:0]  mref [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte array, access size from funct3, extension by plain arithmetic.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit e);
    int n;
    logic [31:0] v;
    e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
        (w && (f3 == 3'd4 || f3 == 3'd5)) ||
        ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ||
        ((f3 == 3'd2) && (a[1:0] != 2'b00)) ||
        (a >= 32'd4096);
    n  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mref[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mref[int'(a) + i];
        if (!f3[2] && n < 4 && v[8*n-1]) begin
          for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        end
        rd = v;
      end
    end
  endtask

  // Response monitor: compares every response taken by the requester.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset === 1'b0 && mif.rsp_valid === 1'b1 && mif.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, mif.rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", mif.rsp_rdata, e[31:0]);
        check("rsp_error", {31'd0, mif.rsp_error}, {31'd0, e[32]});
      end
    end
  end

  task automatic start_req(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mif.req_ready === 1'b1) begin got = 1; break; end
    end
    check("req_ready_timeout", {31'd0, got}, 32'd1);
    mif.req_valid  = 1'b1;
    mif.req_write  = w;
    mif.req_funct3 = f3;
    mif.req_addr   = a;
    mif.req_wdata  = wd;
    @(posedge clk);
    #1 mif.req_valid = 1'b0;
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee, input int hold);
    int lat = 0;
    bit got = 0;
    exp_q.push_back({ee, er});
    mif.rsp_ready = (hold == 0);
    start_req(w, f3, a, wd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.rsp_valid === 1'b1) begin got = 1; break; end
      lat++;
    end
    check("rsp_valid_timeout", {31'd0, got}, 32'd1);
    if (!got) begin
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      mif.rsp_ready = 1'b1;
      return;
    end
    check("rsp_latency", lat, LAT);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        check("bp_valid", {31'd0, mif.rsp_valid}, 32'd1);
        check("bp_rdata", mif.rsp_rdata, er);
        check("bp_error", {31'd0, mif.rsp_error}, {31'd0, ee});
        check("bp_req_ready", {31'd0, mif.req_ready}, 32'd0);
        @(posedge clk);
        #1 mif.req_valid = ~mif.req_valid;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      mif.req_valid = 1'b0;
      mif.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_ready", {31'd0, mif.req_ready}, 32'd1);
      check("bp_idle_valid", {31'd0, mif.rsp_valid}, 32'd0);
      for (int i = 0; i < int'(LAT) + 2; i++) begin
        @(negedge clk);
        check("bp_no_extra_accept", {31'd0, mif.rsp_valid}, 32'd0);
      end
    end else begin
      got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (mif.rsp_valid === 1'b0) begin got = 1; break; end
      end
      check("rsp_drop_timeout", {31'd0, got}, 32'd1);
    end
  endtask

  // Directed transaction: literal expectation, reference model kept in step.
  task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input bit ee, input int hold);
    logic [31:0] rd;
    bit e;
    model(w, f3, a, wd, rd, e);
    do_req(w, f3, a, wd, er, ee, hold);
  endtask

  task automatic rtxn(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] rd;
    bit e;
    model(w, f3, a, wd, rd, e);
    do_req(w, f3, a, wd, rd, e, hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit e;
    bit got;
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    int hold;

    reset = 1'b1;
    mif.req_valid = 1'b0; mif.req_write = 1'b0; mif.req_funct3 = 3'd0;
    mif.req_addr = 32'd0; mif.req_wdata = 32'd0; mif.rsp_ready = 1'b1;
    mif0.req_valid = 1'b0; mif0.req_write = 1'b0; mif0.req_funct3 = 3'd0;
    mif0.req_addr = 32'd0; mif0.req_wdata = 32'd0; mif0.rsp_ready = 1'b1;
    #1;
    check("rst_rsp_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", mif.rsp_rdata, 32'd0);
    check("rst_rsp_error", {31'd0, mif.rsp_error}, 32'd0);
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, mif.req_ready}, 32'd1);

    // Word store/load and sub-word loads.
    txn(1, 3'b010, 32'h020, 32'h0BADF00D, 32'h0, 0, 0);
    txn(1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0, 0);
    txn(0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, 0);
    txn(0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFDE, 0, 0);
    txn(0, 3'b100, 32'h013, 32'h0, 32'h000000DE, 0, 0);
    txn(0, 3'b001, 32'h012, 32'h0, 32'hFFFFDEAD, 0, 0);
    txn(0, 3'b101, 32'h012, 32'h0, 32'h0000DEAD, 0, 0);
    txn(0, 3'b000, 32'h010, 32'h0, 32'hFFFFFFEF, 0, 0);
    // Partial stores.
    txn(1, 3'b000, 32'h011, 32'h123456AA, 32'h0, 0, 0);
    txn(0, 3'b010, 32'h010, 32'h0, 32'hDEADAAEF, 0, 0);
    txn(1, 3'b001, 32'h012, 32'h00001234, 32'h0, 0, 0);
    txn(0, 3'b010, 32'h010, 32'h0, 32'h1234AAEF, 0, 0);
    // Errors.
    txn(1, 3'b010, 32'h014, 32'h55667788, 32'h0, 0, 0);
    txn(0, 3'b010, 32'h012, 32'h0, 32'h0, 1, 0);
    txn(1, 3'b010, 32'h016, 32'hFFFFFFFF, 32'h0, 1, 0);
    txn(0, 3'b010, 32'h014, 32'h0, 32'h55667788, 0, 0);
    txn(0, 3'b011, 32'h014, 32'h0, 32'h0, 1, 0);
    txn(0, 3'b010, 32'h00001000, 32'h0, 32'h0, 1, 0);
    txn(1, 3'b100, 32'h014, 32'hFFFFFFFF, 32'h0, 1, 0);
    txn(0, 3'b010, 32'h014, 32'h0, 32'h55667788, 0, 0);
    // Backpressure in RESP.
    txn(0, 3'b010, 32'h010, 32'h0, 32'h1234AAEF, 0, 5);

    // Reset while the store waits: not committed.
    mif.rsp_ready = 1'b1;
    start_req(1, 3'b010, 32'h020, 32'h12345678);
    #2 reset = 1'b1;
    #1;
    check("rst_wait_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("rst_wait_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_wait_ready", {31'd0, mif.req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    txn(0, 3'b010, 32'h020, 32'h0, 32'h0BADF00D, 0, 0);

    // Reset while the store response is held: already committed.
    mif.rsp_ready = 1'b0;
    start_req(1, 3'b010, 32'h020, 32'h12345678);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.rsp_valid === 1'b1) begin got = 1; break; end
    end
    check("rst_resp_reach", {31'd0, got}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_resp_valid", {31'd0, mif.rsp_valid}, 32'd0);
    check("rst_resp_rdata", mif.rsp_rdata, 32'd0);
    check("rst_resp_error", {31'd0, mif.rsp_error}, 32'd0);
    check("rst_resp_busy", {31'd0, mif.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mif.rsp_ready = 1'b1;
    model(1, 3'b010, 32'h020, 32'h12345678, rd, e);
    txn(0, 3'b010, 32'h020, 32'h0, 32'h12345678, 0, 0);

    // Zero-latency instance: response at the accept edge, one transaction per two edges.
    @(negedge clk);
    mif0.req_valid  = 1'b1;
    mif0.req_write  = 1'b1;
    mif0.req_funct3 = 3'b010;
    mif0.req_addr   = 32'h040;
    mif0.req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("l0_sw_valid", {31'd0, mif0.rsp_valid}, 32'd1);
    check("l0_sw_error", {31'd0, mif0.rsp_error}, 32'd0);
    check("l0_sw_rdata", mif0.rsp_rdata, 32'd0);
    mif0.req_write = 1'b0;
    @(posedge clk);
    #1;
    check("l0_idle_valid", {31'd0, mif0.rsp_valid}, 32'd0);
    check("l0_idle_ready", {31'd0, mif0.req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("l0_lw_valid", {31'd0, mif0.rsp_valid}, 32'd1);
      check("l0_lw_rdata", mif0.rsp_rdata, 32'hCAFEF00D);
      if (k == 2) mif0.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("l0_gap_valid", {31'd0, mif0.rsp_valid}, 32'd0);
    end

    // Randomized traffic over a fully initialized 64-byte window.
    for (int wi = 0; wi < 16; wi++) begin
      rtxn(1, 3'b010, 32'(wi * 4), $urandom, 0);
    end
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 63));
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      rtxn(w, f3, a, $urandom, hold);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Handshaked data-memory slave, the responder end of the core's load/store port (mem_read/mem_write, funct3, addr, write_data, read_data). It accepts one request at a time and applies RV32I load/store width and sign rules. A programmable number of wait states models slower memory. It returns read data or an error flag through a valid/ready response channel, which lets a multi-cycle or pipelined core stall on memory.

Parameters:
ADDR_WIDTH, 10, word-address bits; array holds 2**ADDR_WIDTH 32-bit words (byte range 0 .. 2**(ADDR_WIDTH+2)-1).
LATENCY, 2, wait states between accept and response; legal 0..15.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned (SB uses [7:0], SH uses [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes response
rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
rsp_error  out  1  request rejected
busy  out  1  transaction in progress

Behaviour:
- Reset (async): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0. Memory array is not cleared.
- States:
  - IDLE: req_ready=1, busy=0.
  - WAIT: req_ready=0, busy=1.
  - RESP: req_ready=0, busy=1, rsp_valid=1.
- Accept edge: a rising edge with req_valid & req_ready.
  - At this edge: latch write, funct3, addr and wdata; compute err.
  - LATENCY=0: go directly to RESP.
  - Otherwise: go to WAIT with cnt=LATENCY.
- WAIT: cnt decrements each edge. The edge at which cnt==1 moves to RESP.
- Response timing: rsp_valid rises exactly LATENCY edges after the accept edge (LATENCY=0: at the accept edge itself).
- Commit on the edge entering RESP:
  - Store with !err: update selected bytes; other bytes unchanged.
  - Load with !err: rsp_rdata = extended data.
  - Otherwise rsp_rdata = 0.
  - rsp_error = err.
- RESP: rsp_valid, rsp_rdata and rsp_error stay stable until rsp_ready=1. The handshake edge moves to IDLE and clears rsp_valid.
  - req_valid is ignored outside IDLE.
  - No same-edge re-accept: minimum spacing between accepts is LATENCY+2 edges with rsp_ready held high.
- Memory is little-endian. Word index = addr[ADDR_WIDTH+1:2]; byte lane = addr[1:0].
- funct3 decode:
  - 000 = LB/SB
  - 001 = LH/SH
  - 010 = LW/SW
  - 100 = LBU (load only)
  - 101 = LHU (load only)
- LB/LH sign-extend; LBU/LHU zero-extend.
- err is set when any of these holds:
  - undefined funct3 (011, 110, 111, or 100/101 with write);
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_WIDTH+2] nonzero.
- An erroring store never modifies memory.
- Reset mid-transaction:
  - Pending transaction is dropped and outputs clear immediately.
  - A store still in WAIT is not committed.
  - A store already in RESP has committed and remains.

Test Plan (LATENCY=2, ADDR_WIDTH=10):
- SW 0x010 wdata 0xDEADBEEF, then LW 0x010: rsp_valid rises 2 edges after each accept edge; LW rdata=0xDEADBEEF, error=0; store response rdata=0.
- After the above, loads:
  - LB 0x013 -> 0xFFFFFFDE
  - LBU 0x013 -> 0x000000DE
  - LH 0x012 -> 0xFFFFDEAD
  - LHU 0x012 -> 0x0000DEAD
  - LB 0x010 -> 0xFFFFFFEF
- SB 0x011 wdata 0x123456AA, then LW 0x010 -> 0xDEADAAEF. SH 0x012 wdata 0x00001234, then LW 0x010 -> 0x1234AAEF.
- Errors:
  - LW 0x012 -> error=1, rdata=0.
  - SW 0x016 wdata 0xFFFFFFFF -> error=1; subsequent LW 0x014 is unchanged.
  - funct3 011 -> error=1.
  - LW 0x00001000 -> error=1.
  - Store with funct3 100 -> error=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid. rsp_valid/rdata/error stay stable, req_ready=0, no extra accept. After the rsp_ready handshake, IDLE and req_ready=1 on the next cycle.
- Reset:
  - Assert reset asynchronously in WAIT of SW 0x020 wdata 0x12345678. Outputs clear without a clock edge. LW 0x020 afterwards returns the prior value (previously written 0x0BADF00D).
  - Repeat with reset in RESP: LW returns 0x12345678.
- LATENCY=0 build: LW accepted at edge N has rsp_valid=1 after edge N. Back-to-back loads with rsp_ready tied high complete every 2 edges.
